// File: rtl/mul_repadd_pkg.sv
// mul_repadd_pkg: shared controller state type and default iteration limit
package mul_repadd_pkg;
    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, ADD, DONE} state_t;
    localparam int MAX_ITER_DEF = 255;
endpackage

// File: rtl/mul_repadd_ctrl_iter.sv
// mul_iter_counter: saturating iteration counter with an at-limit flag
//   clk, rst     clock, asynchronous active-high reset
//   clear        force count to zero
//   en           count one iteration (ignored once at_max)
//   count        iterations counted so far
//   at_max       count has reached MAX_ITER
module mul_iter_counter #(
    parameter int MAX_ITER = 255,
    parameter int CW = $clog2(MAX_ITER + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          at_max
);
    assign at_max = count == CW'(MAX_ITER);

    always_ff @(posedge clk or posedge rst)
        if (rst)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (en && !at_max)
            count <= count + 1'b1;
endmodule

// File: rtl/mul_repadd_ctrl.sv
// mul_repadd_ctrl: sequencing FSM for a repeated-addition multiplier datapath
//   clk, rst            clock, asynchronous active-high reset
//   start, abort        request a multiply / cancel the current one
//   op_valid, op_ready  operand handshake on the shared data_in bus
//   eqz                 datapath status B==0
//   ldA, clrs, ldB      operand load strobes (clrs clears S alongside A load)
//   ldS, decB           one add iteration: S<=S+A, B<=B-1
//   busy, done, err     status: active, product-valid pulse, sticky guard trip
//   iter_cnt            add iterations issued in the current operation
module mul_repadd_ctrl
    import mul_repadd_pkg::*;
#(
    parameter int MAX_ITER = MAX_ITER_DEF,
    parameter int CW = $clog2(MAX_ITER + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          op_valid,
    output logic          op_ready,
    input  logic          eqz,
    output logic          ldA,
    output logic          clrs,
    output logic          ldB,
    output logic          ldS,
    output logic          decB,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [CW-1:0] iter_cnt
);
    state_t state, next;
    logic cnt_clr, cnt_en, at_max, err_set, err_clr;

    mul_iter_counter #(.MAX_ITER(MAX_ITER), .CW(CW)) u_iter (
        .clk    (clk),
        .rst    (rst),
        .clear  (cnt_clr),
        .en     (cnt_en),
        .count  (iter_cnt),
        .at_max (at_max)
    );

    assign busy = state != IDLE;
    assign done = state == DONE;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            err   <= 1'b0;
        end else begin
            state <= next;
            if (err_clr)
                err <= 1'b0;
            else if (err_set)
                err <= 1'b1;
        end

    // abort is checked before every other input so no strobe can leak out
    // in the cycle it is raised
    always_comb begin
        next     = state;
        op_ready = 1'b0;
        ldA      = 1'b0;
        clrs     = 1'b0;
        ldB      = 1'b0;
        ldS      = 1'b0;
        decB     = 1'b0;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;
        err_set  = 1'b0;
        err_clr  = 1'b0;
        case (state)
            IDLE:
                if (start && !abort) begin
                    next    = LOAD_A;
                    cnt_clr = 1'b1;
                    err_clr = 1'b1;
                end
            LOAD_A:
                if (abort)
                    next = IDLE;
                else if (op_valid) begin
                    ldA      = 1'b1;
                    clrs     = 1'b1;
                    op_ready = 1'b1;
                    next     = LOAD_B;
                end
            LOAD_B:
                if (abort)
                    next = IDLE;
                else if (op_valid) begin
                    ldB      = 1'b1;
                    op_ready = 1'b1;
                    next     = ADD;
                end
            ADD:
                if (abort)
                    next = IDLE;
                else if (eqz)
                    next = DONE;
                else if (at_max) begin
                    err_set = 1'b1;
                    next    = IDLE;
                end else begin
                    ldS    = 1'b1;
                    decB   = 1'b1;
                    cnt_en = 1'b1;
                end
            DONE:
                next = IDLE;
            default:
                next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mul_repadd_ctrl.sv
// tb_mul_repadd_ctrl: self-checking bench with a behavioural datapath and scoreboard
module tb_mul_repadd_ctrl;
    logic clk = 0, rst = 1;
    logic start = 0, abort = 0, op_valid = 0;
    logic op_ready, eqz, ldA, clrs, ldB, ldS, decB, busy, done, err;
    logic [7:0] iter_cnt;
    logic [7:0] data_in = 0, ra = 0, rb = 0;
    logic [15:0] rs = 0;

    logic start2 = 0, abort2 = 0;
    logic op_ready2, ldA2, clrs2, ldB2, ldS2, decB2, busy2, done2, err2;
    logic [2:0] iter_cnt2;

    int checks = 0, fails = 0, strobe_cnt = 0, strobe_cnt2 = 0;

    typedef struct { logic [15:0] s; int it; } exp_t;
    exp_t sb[$];

    typedef struct { logic [7:0] a, b; int gap; } vec_t;
    vec_t vecs[6];

    always #5 clk = ~clk;

    mul_repadd_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .op_valid(op_valid),
        .op_ready(op_ready), .eqz(eqz), .ldA(ldA), .clrs(clrs), .ldB(ldB),
        .ldS(ldS), .decB(decB), .busy(busy), .done(done), .err(err), .iter_cnt(iter_cnt)
    );

    mul_repadd_ctrl #(.MAX_ITER(4)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .abort(abort2), .op_valid(1'b1),
        .op_ready(op_ready2), .eqz(1'b0), .ldA(ldA2), .clrs(clrs2), .ldB(ldB2),
        .ldS(ldS2), .decB(decB2), .busy(busy2), .done(done2), .err(err2), .iter_cnt(iter_cnt2)
    );

    // datapath has no reset: controller reset must leave it untouched
    assign eqz = rb == 0;
    always @(posedge clk) begin
        if (ldA) ra <= data_in;
        if (ldB) rb <= data_in;
        else if (decB) rb <= rb - 1'b1;
        if (clrs) rs <= '0;
        else if (ldS) rs <= rs + 16'(ra);
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (ldS) strobe_cnt++;
        if (ldS2) strobe_cnt2++;
        check("lds_decb_pair", int'(ldS), int'(decB));
        if (!busy) check("idle_no_strobe", int'({ldS, decB, ldA, ldB, clrs}), 0);
        if (!op_valid) check("no_load_wo_valid", int'({ldA, ldB, clrs, op_ready}), 0);
        if (done) begin
            if (sb.size() == 0)
                check("unexpected_done", 1, 0);
            else begin
                exp_t e;
                e = sb.pop_front();
                check("product_s", int'(rs), int'(e.s));
                check("iter_at_done", int'(iter_cnt), e.it);
                check("err_at_done", int'(err), 0);
            end
        end
    end

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int gap);
        int n, loads, g;
        bit got;
        sb.push_back('{s: 16'(a) * 16'(b), it: int'(b)});
        strobe_cnt = 0;
        start = 1;
        @(posedge clk); #1 start = 0;
        n = 1; loads = 0; g = 0; got = 0;
        while (!got && n < 600) begin
            op_valid = (loads < 2) && (g >= gap);
            data_in = loads == 0 ? a : b;
            @(negedge clk);
            if (done)
                got = 1;
            else begin
                if (op_ready) begin loads++; g = 0; end
                else if (loads < 2) g++;
                @(posedge clk); #1 n++;
            end
        end
        op_valid = 0;
        check("latency", got ? n : -1, int'(b) + 4 + 2 * gap);
        check("strobe_count", strobe_cnt, int'(b));
        @(posedge clk); #1;
        check("idle_after_done", int'(busy), 0);
    endtask

    initial begin
        vecs[0] = '{a: 8'h05, b: 8'h03, gap: 0};
        vecs[1] = '{a: 8'h81, b: 8'h00, gap: 0};
        vecs[2] = '{a: 8'h07, b: 8'h06, gap: 2};
        vecs[3] = '{a: 8'hFF, b: 8'hFF, gap: 0};
        vecs[4] = '{a: 8'h01, b: 8'h01, gap: 1};
        vecs[5] = '{a: 8'h00, b: 8'h09, gap: 0};

        #12;
        check("rst_outputs", int'({busy, done, err, op_ready, ldA, clrs, ldB, ldS, decB}), 0);
        check("rst_iter", int'(iter_cnt), 0);
        @(posedge clk); #1 rst = 0;

        for (int i = 0; i < 6; i++) run_op(vecs[i].a, vecs[i].b, vecs[i].gap);

        // start and abort together in IDLE: abort wins
        start = 1; abort = 1;
        @(posedge clk); #1 start = 0; abort = 0;
        check("start_abort_idle", int'(busy), 0);

        // abort in the second ADD cycle
        start = 1;
        @(posedge clk); #1 start = 0; op_valid = 1; data_in = 3;
        @(posedge clk); #1 data_in = 5;
        @(posedge clk); #1 op_valid = 0;
        @(posedge clk); #1 abort = 1;
        @(negedge clk);
        check("abort_no_strobe", int'({ldS, decB}), 0);
        @(posedge clk); #1 abort = 0;
        check("abort_busy", int'(busy), 0);
        check("abort_iter_hold", int'(iter_cnt), 1);
        check("abort_err", int'(err), 0);
        repeat (5) @(posedge clk);
        #1;

        // runaway guard on the MAX_ITER=4 instance
        strobe_cnt2 = 0;
        start2 = 1;
        @(posedge clk); #1 start2 = 0;
        repeat (12) @(posedge clk);
        #1;
        check("guard_strobes", strobe_cnt2, 4);
        check("guard_err", int'(err2), 1);
        check("guard_busy", int'(busy2), 0);
        check("guard_iter", int'(iter_cnt2), 4);
        check("guard_no_done", int'(done2), 0);
        start2 = 1;
        @(posedge clk); #1 start2 = 0;
        check("guard_err_clear", int'(err2), 0);
        check("guard_restart_busy", int'(busy2), 1);
        abort2 = 1;
        @(posedge clk); #1 abort2 = 0;
        check("guard_abort_idle", int'(busy2), 0);

        // asynchronous reset mid-ADD
        start = 1;
        @(posedge clk); #1 start = 0; op_valid = 1; data_in = 2;
        @(posedge clk); #1 data_in = 10;
        @(posedge clk); #1 op_valid = 0;
        @(posedge clk); #1;
        check("pre_rst_iter", int'(iter_cnt), 1);
        #2 rst = 1;
        #1;
        check("async_rst_outputs", int'({busy, done, err, ldS, decB}), 0);
        check("async_rst_iter", int'(iter_cnt), 0);
        check("dp_b_untouched", int'(rb), 9);
        @(posedge clk); #1 rst = 0;
        run_op(8'h0C, 8'h04, 0);

        check("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", checks, fails);
        $finish;
    end
endmodule
